key_event_ctrl: RTL and testbench
=================================

// Module: key_event_ctrl
// PURPOSE
//  Avalon-MM slave that debounces N_KEYS push-buttons and records press events per key.
//  A round-robin arbiter shares one event FIFO between the keys.
//  The CPU pops key indices from the FIFO instead of polling one edge-capture PIO per key.
//  Sits between the board keys and the Nios II data master; irq goes to the CPU interrupt controller.
// PARAMETERS
//  N_KEYS      4     number of key inputs, 1..8
//  DEB_CYCLES  1000  input must differ from the stable level this many consecutive clks to be accepted
//  FIFO_DEPTH  8     event FIFO entries; power of 2, 2..16
//  ACTIVE_LOW  1     1: pressed = in_port bit low; 0: pressed = high
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       async assert, active-low reset
//  address    in   2       word address: 0 STATE, 1 EVENT, 2 MASK, 3 STATUS
//  chipselect in   1       slave select
//  read_n     in   1       active-low read strobe
//  write_n    in   1       active-low write strobe
//  writedata  in   32      write data
//  readdata   out  32      registered read data, 1-cycle latency
//  irq        out  1       level interrupt
//  in_port    in   N_KEYS  raw key pins, asynchronous
// BEHAVIOUR
//  Reset values:
//   - readdata=0, irq=0, FIFO empty, MASK=0, OVF=0, arbiter pointer=0.
//   - Debounced state = released; sync flops = released level.
//  Debounce, per key:
//   - 2-FF synchroniser, then a counter of width clog2(DEB_CYCLES+1).
//   - Counter clears whenever the synced level equals the stable level.
//   - When the count reaches DEB_CYCLES-1 with the level still different, stable flips and the counter clears.
//   - A released->pressed flip sets pending[k] for one cycle-pulse.
//  Pending:
//   - pending[k] is sticky until granted.
//   - If a new press arrives while pending[k]=1, OVF sets; the event is merged, not queued twice.
//  Arbiter:
//   - Each cycle with FIFO not full, grants the lowest pending index >= ptr, wrapping.
//   - One grant per cycle: pushes k, clears pending[k], and sets ptr=(k+1)%N_KEYS.
//   - FIFO full: no grant; pending bits hold.
//  Register map; readdata = mux(address) registered every clk; read strobe used only for pops:
//   - 0 STATE (R): [N_KEYS-1:0] debounced pressed state, 1 = pressed.
//   - 1 EVENT (R):
//     - fields: [31] valid = !empty; [2:0] head key index; other bits 0.
//     - pop: chipselect & ~read_n & addr==1 & !empty pops; the popped head is what appears in readdata.
//     - empty: read returns 0 and does not pop.
//   - 2 MASK (RW): [0] irq enable; writes take writedata[0].
//   - 3 STATUS (R): [4:0] count, [8] OVF.
//   - 3 STATUS (W): any write flushes the FIFO, clears OVF and clears all pending.
//  FIFO and irq:
//   - Push and pop in the same cycle: both happen; count unchanged.
//   - A flush write in the same cycle as a grant: flush wins, and the push is dropped.
//   - irq = MASK[0] & !empty, registered; one-cycle lag after a FIFO change.
//  Reset mid-operation: all state returns to reset values immediately, including the debounce counters.
// STRUCTURE
//  Shared package key_ctrl_pkg:
//   - constants ADDR_STATE=0, ADDR_EVENT=1, ADDR_MASK=2, ADDR_STATUS=3, EVT_VALID_BIT=31, STAT_OVF_BIT=8.
//   - function clog2.
//  Sub-module key_debounce: one per key, via generate. Ports clk, reset_n, din, stable, press_pulse.
//  Top level holds pending, arbiter, FIFO (reg array + rd/wr pointers + count), regs and irq.
//  Expected size: ~250 RTL lines.
// TESTING (DEB_CYCLES=4 for sim)
//  1. Glitch: key0 pressed 3 clks then released -> STATE=0, count=0, irq=0.
//  2. Single press: key2 held 10 clks, MASK=1 -> STATE bit2=1, then irq=1.
//     Read addr1 -> readdata=0x8000_0002, count 1->0, irq=0 next clk.
//  3. Round-robin: keys 0,1,3 settle in the same clk with ptr=0 -> FIFO order 0,1,3.
//     A repeat press of 0,1 then queues after 3.
//  4. Full/overflow, FIFO_DEPTH=8:
//     - 8 presses fill the FIFO; a 9th press of key1 stays pending.
//     - Another key1 press -> OVF=1, STATUS=0x108.
//     - One pop -> key1 is pushed next clk; count stays 8.
//  5. Simultaneous push+pop with count=3 -> count stays 3, head advances.
//     Write addr3 in the same clk as a grant -> count=0, OVF=0.
//  6. Assert reset_n mid-debounce and with FIFO count 5:
//     - readdata, irq, count all 0 asynchronously.
//     - After release, no events until a fresh full debounce.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared constants and helpers for the key event controller.
// Register map addresses, bit positions and the decoded bus command struct.
package key_ctrl_pkg;

    localparam logic [1:0] ADDR_STATE  = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int EVT_VALID_BIT = 31;
    localparam int STAT_OVF_BIT  = 8;

    typedef struct packed {
        logic pop_req;
        logic mask_we;
        logic flush;
    } bus_cmd_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-FF synchroniser plus a consecutive-difference counter.
// stable is the debounced pressed state; press_pulse marks a released->pressed flip.
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic press_pulse
);

    localparam int   CW  = clog2(DEB_CYCLES + 1);
    localparam logic REL = ACTIVE_LOW;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          pressed_s;

    assign pressed_s = sync[1] ^ REL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= {2{REL}};
            cnt         <= '0;
            stable      <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], din};
            press_pulse <= 1'b0;
            if (pressed_s == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable      <= pressed_s;
                cnt         <= '0;
                press_pulse <= pressed_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key event controller: per-key debounce, sticky pending bits,
// round-robin grant into a shared event FIFO, register file and level irq.
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int DEB_CYCLES = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [N_KEYS-1:0] in_port
);

    localparam int         AW   = clog2(FIFO_DEPTH);
    localparam int         CNTW = clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] NK4  = 4'(N_KEYS);

    logic [N_KEYS-1:0] stable_vec, press_vec, pending, grant_oh;
    logic              ovf, mask;
    logic [2:0]        ptr, grant_off, grant_idx, ptr_nxt;
    logic [3:0]        grant_sum;
    logic              grant_vld, push, pop, empty, full;
    logic [2*N_KEYS-1:0] rot;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CNTW-1:0]   count;
    logic [2:0]        mem [FIFO_DEPTH];
    logic [31:0]       rd_mux;
    bus_cmd_t          cmd;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:1];

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_deb (
            .clk         (clk),
            .reset_n     (reset_n),
            .din         (in_port[g]),
            .stable      (stable_vec[g]),
            .press_pulse (press_vec[g])
        );
    end

    always_comb begin
        cmd.pop_req = chipselect & ~read_n  & (address == ADDR_EVENT);
        cmd.mask_we = chipselect & ~write_n & (address == ADDR_MASK);
        cmd.flush   = chipselect & ~write_n & (address == ADDR_STATUS);
    end

    assign empty = (count == '0);
    assign full  = (count == CNTW'(FIFO_DEPTH));
    assign pop   = cmd.pop_req & ~empty & ~cmd.flush;
    assign push  = grant_vld & ~cmd.flush;

    // Rotate pending so bit 0 is the key at ptr; the lowest set bit is the grant.
    always_comb begin
        rot       = {pending, pending} >> ptr;
        grant_vld = 1'b0;
        grant_off = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_vld = 1'b1;
                grant_off = 3'(i);
            end
        end
        if (full) grant_vld = 1'b0;
        grant_sum = {1'b0, ptr} + {1'b0, grant_off};
        grant_idx = (grant_sum >= NK4) ? 3'(grant_sum - NK4) : grant_sum[2:0];
        ptr_nxt   = ({1'b0, grant_idx} + 4'd1 == NK4) ? 3'd0 : grant_idx + 3'd1;
        grant_oh  = grant_vld ? (N_KEYS'(1) << grant_idx) : '0;
    end

    // A press that lands on a still-pending key is merged and flagged as overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            ovf     <= 1'b0;
            ptr     <= '0;
        end else begin
            if (grant_vld) ptr <= ptr_nxt;
            if (cmd.flush) begin
                pending <= '0;
                ovf     <= 1'b0;
            end else begin
                pending <= (pending & ~grant_oh) | press_vec;
                if (|(press_vec & pending & ~grant_oh)) ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cmd.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= grant_idx;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATE: rd_mux[N_KEYS-1:0] = stable_vec;
            ADDR_EVENT: begin
                if (!empty) begin
                    rd_mux[EVT_VALID_BIT] = 1'b1;
                    rd_mux[2:0]           = mem[rd_ptr];
                end
            end
            ADDR_MASK:  rd_mux[0] = mask;
            default: begin
                rd_mux[CNTW-1:0]     = count;
                rd_mux[STAT_OVF_BIT] = ovf;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
            mask     <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= mask & ~empty;
            if (cmd.mask_we) mask <= writedata[0];
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised scoreboard bench for key_event_ctrl against a queue-based event model.
module tb_key_event_ctrl;

    localparam int N_KEYS = 4;
    localparam int DEB    = 4;
    localparam int DEPTH  = 8;
    localparam int HOLD   = DEB + 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              read_n = 1'b1;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [N_KEYS-1:0] prs = '0;
    logic [N_KEYS-1:0] in_port;

    assign in_port = ~prs;

    key_event_ctrl #(
        .N_KEYS(N_KEYS), .DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .in_port(in_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit                m_pend [N_KEYS];
    int                m_ptr = 0;
    int                m_fifo [$];
    bit                m_ovf = 1'b0;
    bit                m_mask = 1'b0;
    logic [N_KEYS-1:0] m_state = '0;

    logic [31:0] exp_q [$];
    string       exp_n [$];
    logic        rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read sampled on a rising edge shows its data one cycle later.
    always @(posedge clk) rd_seen <= chipselect & ~read_n;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected none", readdata);
            end else begin
                chk(exp_n.pop_front(), readdata, exp_q.pop_front());
            end
        end
    end

    function automatic void m_drain();
        int k, j;
        while (m_fifo.size() < DEPTH) begin
            k = -1;
            for (int i = 0; i < N_KEYS; i++) begin
                j = (m_ptr + i) % N_KEYS;
                if (k < 0 && m_pend[j]) k = j;
            end
            if (k < 0) break;
            m_fifo.push_back(k);
            m_pend[k] = 1'b0;
            m_ptr = (k + 1) % N_KEYS;
        end
    endfunction

    function automatic void m_press(input logic [N_KEYS-1:0] keys);
        for (int k = 0; k < N_KEYS; k++) begin
            if (keys[k]) begin
                if (m_pend[k]) m_ovf = 1'b1;
                else m_pend[k] = 1'b1;
            end
        end
        m_drain();
    endfunction

    function automatic void m_flush();
        m_fifo.delete();
        for (int k = 0; k < N_KEYS; k++) m_pend[k] = 1'b0;
        m_ovf = 1'b0;
    endfunction

    function automatic logic [31:0] m_expect(input logic [1:0] a);
        logic [31:0] v;
        case (a)
            2'd0: v = 32'(m_state);
            2'd1: begin
                if (m_fifo.size() == 0) v = '0;
                else begin
                    v = 32'h8000_0000 | 32'(m_fifo.pop_front());
                    m_drain();
                end
            end
            2'd2: v = 32'(m_mask);
            default: v = (32'(m_ovf) << 8) | 32'(m_fifo.size());
        endcase
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chipselect = 1'b1;
            read_n     = 1'b0;
            address    = a;
            exp_q.push_back(m_expect(a));
            exp_n.push_back($sformatf("read_addr%0d", a));
        end
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        idle(2);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        if (a == 2'd2) m_mask = d[0];
        if (a == 2'd3) m_flush();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(2);
    endtask

    // Hold keys long enough to be accepted; glitch keys drop out after glen clks.
    task automatic press(input logic [N_KEYS-1:0] keys, input logic [N_KEYS-1:0] glitch,
                         input int glen);
        @(negedge clk);
        prs = keys | glitch;
        for (int c = 1; c <= HOLD; c++) begin
            @(negedge clk);
            if (c == glen) prs = keys;
        end
        m_press(keys);
        m_state = keys;
        rd(2'd0);
        prs = '0;
        idle(HOLD);
        m_state = '0;
    endtask

    task automatic chk_irq();
        chk("irq", 32'(irq), 32'(m_mask && (m_fifo.size() != 0)));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_KEYS-1:0] keys, gl;
        for (int k = 0; k < N_KEYS; k++) m_pend[k] = 1'b0;
        idle(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        idle(3);

        // Glitch shorter than the debounce window is dropped.
        press('0, 4'b0001, DEB - 1);
        rd(2'd3);
        chk_irq();

        // Simultaneous settle from ptr 0, then a repeat of 0,1.
        press(4'b1011, '0, 0);
        press(4'b0011, '0, 0);
        rd(2'd3);
        rd(2'd1, 1); rd(2'd1, 1); rd(2'd1, 1); rd(2'd1, 1); rd(2'd1, 1);
        rd(2'd1);

        // Single press with irq enabled.
        wr(2'd2, 32'h1);
        press(4'b0100, '0, 0);
        chk_irq();
        rd(2'd1);
        chk_irq();
        rd(2'd3);

        // Fill, pend, overflow, then pops with concurrent refills.
        press(4'b1111, '0, 0);
        press(4'b1111, '0, 0);
        press(4'b0010, '0, 0);
        press(4'b0110, '0, 0);
        rd(2'd3);
        rd(2'd1);
        rd(2'd3);
        rd(2'd1, 2);
        rd(2'd3);

        // Flush lands while the arbiter is granting.
        @(negedge clk);
        prs = 4'b1011;
        idle(6);
        m_press(4'b1011);
        wr(2'd3, 32'h0);
        idle(HOLD - 9);
        prs = '0;
        idle(HOLD);
        rd(2'd3);
        chk_irq();

        // Reset mid-debounce with a part-filled FIFO.
        press(4'b1111, '0, 0);
        press(4'b0001, '0, 0);
        rd(2'd3);
        chk_irq();
        @(negedge clk);
        prs = 4'b0100;
        idle(2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 32'h0);
        chk("async_reset_irq", 32'(irq), 32'h0);
        m_flush();
        m_mask = 1'b0;
        m_ptr = 0;
        idle(2);
        reset_n = 1'b1;
        rd(2'd3);
        idle(HOLD);
        m_press(4'b0100);
        rd(2'd3);
        prs = '0;
        idle(HOLD);
        chk_irq();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    keys = N_KEYS'($urandom);
                    gl   = N_KEYS'($urandom) & ~keys;
                    press(keys, gl, $urandom_range(1, DEB - 1));
                end
                5, 6: rd(2'd1, $urandom_range(1, 3));
                7: rd(2'($urandom_range(0, 3)));
                8: wr(2'd2, $urandom);
                default: begin
                    if ($urandom_range(0, 3) == 0) wr(2'd3, $urandom);
                    else rd(2'd3);
                end
            endcase
            chk_irq();
        end

        idle(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
